// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU writeback buffer: entry field widths,
// occupancy encoding and FP16 classification constants.
package vpu_pkg;

    localparam int HALF_W     = 16;
    localparam int FULL_W     = 32;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_EXP_W = 5;

    localparam logic [FP16_EXP_W-1:0] EXP_ALL1 = 5'h1f;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Register index lives outside this struct because its width is a parameter.
    typedef struct packed {
        logic [HALF_W-1:0] opout;
        logic [FULL_W-1:0] fullout;
        logic              gt;
        logic              eq;
        logic              wfull;
    } wb_data_t;

    function automatic logic [FP16_EXP_W-1:0] fp16_exp(input logic [HALF_W-1:0] h);
        return h[FP16_MAN_W +: FP16_EXP_W];
    endfunction

endpackage

// File: rtl/vpu_wb_buffer_if.sv
// Lane-result input and register-file output bundle of the writeback buffer.
// slave = buffer side, master = producer/consumer environment side.
interface vpu_wb_buffer_if
    import vpu_pkg::*;
#(
    parameter int RD_W = 5
);

    logic              in_valid;
    logic              in_ready;
    logic [HALF_W-1:0] in_opout;
    logic [FULL_W-1:0] in_fullout;
    logic              in_gt;
    logic              in_eq;
    logic [RD_W-1:0]   in_rd;
    logic              in_wfull;
    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [HALF_W-1:0] out_opout;
    logic [FULL_W-1:0] out_fullout;
    logic              out_gt;
    logic              out_eq;
    logic [RD_W-1:0]   out_rd;
    logic              out_wfull;

    logic              flag_nan;
    logic              flag_inf;
    logic              flag_clr;

    modport slave (
        input  in_valid, in_opout, in_fullout, in_gt, in_eq, in_rd, in_wfull, flush,
        input  out_ready, flag_clr,
        output in_ready, out_valid, out_opout, out_fullout, out_gt, out_eq, out_rd, out_wfull,
        output flag_nan, flag_inf
    );

    modport master (
        output in_valid, in_opout, in_fullout, in_gt, in_eq, in_rd, in_wfull, flush,
        output out_ready, flag_clr,
        input  in_ready, out_valid, out_opout, out_fullout, out_gt, out_eq, out_rd, out_wfull,
        input  flag_nan, flag_inf
    );

endinterface

// File: rtl/fp16_class.sv
// Combinational classifier of an IEEE half: NaN, infinity, zero (either sign).
module fp16_class
    import vpu_pkg::*;
(
    input  logic [HALF_W-1:0] h,
    output logic              is_nan,
    output logic              is_inf,
    output logic              is_zero
);

    logic exp_all1;
    logic man_zero;
    logic unused_sign;

    assign exp_all1    = (fp16_exp(h) == EXP_ALL1);
    assign man_zero    = (h[FP16_MAN_W-1:0] == '0);
    assign is_nan      = exp_all1 & ~man_zero;
    assign is_inf      = exp_all1 & man_zero;
    assign is_zero     = (fp16_exp(h) == '0) & man_zero;
    assign unused_sign = h[HALF_W-1];

endmodule

// File: rtl/vpu_wb_buffer.sv
// Two-entry writeback skid FIFO between the lane ALUs and the register file.
// Optional sticky NaN/Inf status on popped half results: define VPU_WB_FLAGS_EN.
module vpu_wb_buffer
    import vpu_pkg::*;
#(
    parameter int RD_W = 5
) (
    input logic            clk,
    input logic            rst,
    vpu_wb_buffer_if.slave bus
);

    occ_e            state;
    wb_data_t        data0, data1;
    logic [RD_W-1:0] rd0, rd1;
    wb_data_t        in_data;
    logic            push, pop;

    // in_ready depends only on registered state and reset, never on out_ready.
    assign bus.in_ready  = ~rst & (state != OCC_FULL);
    assign bus.out_valid = (state != OCC_EMPTY);

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    assign in_data = '{opout:   bus.in_opout,
                       fullout: bus.in_fullout,
                       gt:      bus.in_gt,
                       eq:      bus.in_eq,
                       wfull:   bus.in_wfull};

    // data0/rd0 is always the head; data1/rd1 holds the younger entry in FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OCC_EMPTY;
            data0 <= '0;
            data1 <= '0;
            rd0   <= '0;
            rd1   <= '0;
        end else if (bus.flush) begin
            state <= OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        data0 <= in_data;
                        rd0   <= bus.in_rd;
                        state <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        data0 <= in_data;
                        rd0   <= bus.in_rd;
                    end else if (push) begin
                        data1 <= in_data;
                        rd1   <= bus.in_rd;
                        state <= OCC_FULL;
                    end else if (pop) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        data0 <= data1;
                        rd0   <= rd1;
                        state <= OCC_ONE;
                    end
                end
                default: state <= OCC_EMPTY;
            endcase
        end
    end

    assign bus.out_opout   = data0.opout;
    assign bus.out_fullout = data0.fullout;
    assign bus.out_gt      = data0.gt;
    assign bus.out_eq      = data0.eq;
    assign bus.out_wfull   = data0.wfull;
    assign bus.out_rd      = rd0;

`ifdef VPU_WB_FLAGS_EN
    logic is_nan, is_inf, is_zero;
    logic half_pop;
    logic nan_q, inf_q;
    logic unused_zero;

    fp16_class u_cls (
        .h       (data0.opout),
        .is_nan  (is_nan),
        .is_inf  (is_inf),
        .is_zero (is_zero)
    );

    // A pop squashed by flush never reaches the register file, so it cannot set a flag.
    assign half_pop    = pop & ~bus.flush & ~data0.wfull;
    assign unused_zero = is_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_q <= 1'b0;
            inf_q <= 1'b0;
        end else begin
            nan_q <= (half_pop & is_nan) | (nan_q & ~bus.flag_clr);
            inf_q <= (half_pop & is_inf) | (inf_q & ~bus.flag_clr);
        end
    end

    assign bus.flag_nan = nan_q;
    assign bus.flag_inf = inf_q;
`else
    logic unused_clr;

    assign unused_clr   = bus.flag_clr;
    assign bus.flag_nan = 1'b0;
    assign bus.flag_inf = 1'b0;
`endif

endmodule

// File: tb/tb_vpu_wb_buffer.sv
// Bench for vpu_wb_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vpu_wb_buffer;

    localparam int RD_W = 5;
`ifdef VPU_WB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        logic [15:0]     opout;
        logic [31:0]     fullout;
        logic            gt;
        logic            eq;
        logic [RD_W-1:0] rd;
        logic            wfull;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    vpu_wb_buffer_if #(.RD_W(RD_W)) bus ();

    vpu_wb_buffer #(.RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue of capacity 2 and two sticky bits.
    ent_t q[$];
    bit   m_nan, m_inf;

    function automatic bit is_nan16(input logic [15:0] h);
        return ((h >> 10) & 16'h1f) == 16'h1f && (h & 16'h3ff) != 0;
    endfunction

    function automatic bit is_inf16(input logic [15:0] h);
        return ((h >> 10) & 16'h1f) == 16'h1f && (h & 16'h3ff) == 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_nan = 0;
            m_inf = 0;
        end else begin
            bit   do_push, do_pop, set_n, set_i;
            ent_t e;
            do_push = bus.in_valid && q.size() < 2;
            do_pop  = q.size() > 0 && bus.out_ready;
            set_n   = 0;
            set_i   = 0;
            if (bus.flush) begin
                q.delete();
            end else begin
                if (do_pop) begin
                    if (!q[0].wfull) begin
                        set_n = is_nan16(q[0].opout);
                        set_i = is_inf16(q[0].opout);
                    end
                    void'(q.pop_front());
                end
                if (do_push) begin
                    e = '{bus.in_opout, bus.in_fullout, bus.in_gt, bus.in_eq, bus.in_rd, bus.in_wfull};
                    q.push_back(e);
                end
            end
            if (FLAGS) begin
                m_nan = set_n || (m_nan && !bus.flag_clr);
                m_inf = set_i || (m_inf && !bus.flag_clr);
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", bus.in_ready, (!rst && q.size() < 2));
        chk("out_valid", bus.out_valid, (!rst && q.size() > 0));
        chk("flag_nan", bus.flag_nan, m_nan);
        chk("flag_inf", bus.flag_inf, m_inf);
        if (!rst && q.size() > 0) begin
            chk("head_opout", bus.out_opout, q[0].opout);
            chk("head_fullout", bus.out_fullout, q[0].fullout);
            chk("head_gt_eq", {bus.out_gt, bus.out_eq}, {q[0].gt, q[0].eq});
            chk("head_rd", bus.out_rd, q[0].rd);
            chk("head_wfull", bus.out_wfull, q[0].wfull);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [15:0] op, input logic [RD_W-1:0] rd, input bit wf);
        bus.in_valid   = v;
        bus.in_opout   = op;
        bus.in_fullout = {op, ~op};
        bus.in_gt      = op[0];
        bus.in_eq      = op[1];
        bus.in_rd      = rd;
        bus.in_wfull   = wf;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 16'h0, 0, 0);
        bus.flush     = 0;
        bus.out_ready = 0;
        bus.flag_clr  = 0;
        #2;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", {bus.out_opout, bus.out_fullout, bus.out_rd}, '0);
        chk("rst_flags", {bus.flag_nan, bus.flag_inf}, 2'b00);
        step(); step();
        rst = 0;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);

        // single push with immediate drain
        drive(1, 16'h3C00, 3, 0);
        bus.out_ready = 1;
        step();
        drive(0, 16'h0, 0, 0);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_opout", bus.out_opout, 16'h3C00);
        chk("t1_rd", bus.out_rd, 3);
        step();
        chk("t1_empty", bus.out_valid, 0);

        // fill to FULL, third push refused, drain in order
        bus.out_ready = 0;
        drive(1, 16'h0001, 1, 0); step();
        drive(1, 16'h0002, 2, 0); step();
        drive(1, 16'h0003, 3, 0);
        chk("t2_full_in_ready", bus.in_ready, 0);
        step();
        drive(0, 16'h0, 0, 0);
        bus.out_ready = 1;
        chk("t2_head0", bus.out_opout, 16'h0001);
        step();
        chk("t2_head1", bus.out_opout, 16'h0002);
        step();
        chk("t2_drained", bus.out_valid, 0);

        // ONE state with simultaneous push and pop
        bus.out_ready = 0;
        drive(1, 16'h1234, 7, 0); step();
        drive(1, 16'h4000, 9, 0);
        bus.out_ready = 1;
        step();
        drive(0, 16'h0, 0, 0);
        bus.out_ready = 0;
        chk("t3_valid", bus.out_valid, 1);
        chk("t3_head", bus.out_opout, 16'h4000);
        chk("t3_one_ready", bus.in_ready, 1);
        bus.out_ready = 1;
        step();

        // sticky flags
        drive(1, 16'h7E00, 1, 0); step();
        drive(0, 16'h0, 0, 0); step();
        chk("t4_nan", {bus.flag_nan, bus.flag_inf}, {FLAGS, 1'b0});
        drive(1, 16'h7C00, 2, 0); step();
        drive(0, 16'h0, 0, 0); step();
        chk("t4_inf", {bus.flag_nan, bus.flag_inf}, {FLAGS, FLAGS});
        bus.flag_clr = 1; step();
        bus.flag_clr = 0;
        chk("t4_clr", {bus.flag_nan, bus.flag_inf}, 2'b00);
        drive(1, 16'h7E00, 3, 1); step();
        drive(0, 16'h0, 0, 0); step();
        chk("t4_wfull", {bus.flag_nan, bus.flag_inf}, 2'b00);

        // flush from FULL overrides a push
        bus.out_ready = 0;
        drive(1, 16'h0011, 4, 0); step();
        drive(1, 16'h0022, 5, 0); step();
        bus.flush = 1;
        drive(1, 16'h0033, 6, 0);
        step();
        bus.flush = 0;
        drive(0, 16'h0, 0, 0);
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_in_ready", bus.in_ready, 1);

        // asynchronous reset while FULL
        drive(1, 16'h0044, 4, 0); step();
        drive(1, 16'h0055, 5, 0); step();
        drive(0, 16'h0, 0, 0);
        #2;
        rst = 1;
        #1;
        chk("t6_async_valid", bus.out_valid, 0);
        chk("t6_async_ready", bus.in_ready, 0);
        chk("t6_async_data", bus.out_opout, 16'h0);
        step();
        rst = 0;
        #1;
        chk("t6_rel_ready", bus.in_ready, 1);
        chk("t6_rel_valid", bus.out_valid, 0);

        // mixed traffic, checked against the model each cycle
        for (int i = 0; i < 200; i++) begin
            logic [15:0] pick;
            case ($urandom_range(0, 3))
                0:       pick = 16'h7E00;
                1:       pick = 16'h7C00;
                default: pick = 16'($urandom);
            endcase
            drive(1'($urandom_range(0, 1)), pick, RD_W'($urandom), 1'($urandom_range(0, 1)));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.flag_clr  = ($urandom_range(0, 11) == 0);
            step();
        end
        drive(0, 16'h0, 0, 0);
        bus.flush    = 0;
        bus.flag_clr = 0;
        bus.out_ready = 1;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/vpu_wb_buffer.md
VPU_WB_BUFFER -- requirements
Module: vpu_wb_buffer

Interface
REQ-001 SHALL have parameter RD_W, default 5: destination register index width.
REQ-002 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1: lane ALU result present.
REQ-005 SHALL have port in_ready  output  1: buffer can accept a result this cycle.
REQ-006 SHALL have port in_opout  input  16: half-precision lane result.
REQ-007 SHALL have port in_fullout  input  32: single-precision result for float register.
REQ-008 SHALL have port in_gt, in_eq  input  1 each: compare flags.
REQ-009 SHALL have port in_rd  input  RD_W: destination register index.
REQ-010 SHALL have port in_wfull  input  1: 1 = write fullout to float reg, 0 = write opout to lane.
REQ-011 SHALL have port flush  input  1: discard all buffered entries.
REQ-012 SHALL have port out_valid  output  1: head entry valid.
REQ-013 SHALL have port out_ready  input  1: register file accepts head.
REQ-014 SHALL have ports out_opout(16), out_fullout(32), out_gt(1), out_eq(1), out_rd(RD_W), out_wfull(1)  output: head entry fields.
REQ-015 SHALL have ports flag_nan, flag_inf  output  1 each: sticky status; flag_clr  input  1: clear them.

Function
REQ-016 SHALL be a 2-entry FIFO with state EMPTY, ONE, FULL (occupancy 0/1/2).
REQ-017 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL, decoded from registered state only (no combinational path from out_ready).
REQ-018 SHALL accept a push when in_valid & in_ready, and a pop when out_valid & out_ready.
REQ-019 SHALL drive out_valid = 1 in ONE and FULL; outputs present the oldest entry.
REQ-020 SHALL give latency 1 cycle: a push at edge N makes out_valid high after edge N when previously EMPTY.
REQ-021 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE (new entry becomes head); FULL+pop->ONE; otherwise hold.
REQ-022 SHALL preserve order: entries pop in push order; head data SHALL not change while out_valid & !out_ready.
REQ-023 flush SHALL force state EMPTY next cycle, overriding push and pop in that cycle; flags unaffected.
REQ-024 Output data fields when out_valid = 0 SHALL be don't-care; bench checks them only when out_valid = 1.

Reset
REQ-025 rst SHALL asynchronously force state EMPTY, in_ready = 0 while rst asserted and 1 the first cycle after release.
REQ-026 rst SHALL force out_valid = 0, all out_* data fields = 0, flag_nan = flag_inf = 0.
REQ-027 A push coincident with rst deassertion edge SHALL be ignored.

Configuration
REQ-028 Macro VPU_WB_FLAGS_EN SHALL compile in the sticky flag logic.
REQ-029 With VPU_WB_FLAGS_EN: on each pop with out_wfull = 0, flag_nan sets if out_opout[14:10] = 5'h1f and out_opout[9:0] != 0; flag_inf sets if out_opout[14:10] = 5'h1f and out_opout[9:0] = 0.
REQ-030 With VPU_WB_FLAGS_EN: flag_clr clears both flags next cycle; set in same cycle as clr SHALL win.
REQ-031 Without VPU_WB_FLAGS_EN: flag_nan and flag_inf SHALL be constant 0, flag_clr ignored, no flag registers generated.

Structure
REQ-032 Shared package vpu_pkg SHALL hold the entry field widths (16 half, 32 full), the 3-state occupancy enumeration and FP16 constants EXP_ALL1 = 5'h1f.
REQ-033 SHALL contain one sub-module fp16_class (combinational NaN/Inf/zero classifier of a 16-bit half), instantiated only under VPU_WB_FLAGS_EN.

Verification
REQ-034 Single push opout=16'h3C00, rd=3, out_ready=1 -> out_valid high one cycle later with out_opout=16'h3C00, out_rd=3; then EMPTY.
REQ-035 Three pushes (16'h0001, 16'h0002, 16'h0003) with out_ready=0 -> first two accepted, in_ready=0 on third, state FULL; release out_ready -> pops 0001 then 0002 in order.
REQ-036 ONE state, simultaneous push 16'h4000 and pop -> state stays ONE, head becomes 16'h4000.
REQ-037 Push 16'h7E00 (wfull=0) and pop -> flag_nan=1, flag_inf=0; push 16'h7C00 and pop -> flag_inf=1; flag_clr with no pop -> both 0 next cycle; push 16'h7E00 with wfull=1 -> flags stay 0.
REQ-038 FULL state, assert flush together with in_valid -> next cycle EMPTY, out_valid=0, in_ready=1.
REQ-039 Assert rst mid-operation in FULL state -> out_valid=0, in_ready=0 immediately without a clock edge; after release in_ready=1, out_valid=0.
